// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its front-end arbiter:
//   - W, OP_W        default operand and opcode widths
//   - alu_op_e       opcode encodings decoded by alu
//   - REQ_EX/REQ_AUX requester indices used by the arbiter
//   - alu_uses_sub() true for opcodes whose adder path subtracts
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int W    = 32;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam int REQ_EX  = 0;
  localparam int REQ_AUX = 1;

  // The zero flag always comes from the adder; compare-type opcodes drive it
  // in subtract mode so that zero means "operands equal".
  function automatic logic alu_uses_sub(input logic [OP_W-1:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational ALU.
//   a_i, b_i   operands (W bits)
//   alu_op_i   opcode (alu_pkg::alu_op_e encodings)
//   c_o        result
//   zero_o     adder-path result is zero (a+b, or a-b for SUB/SLT/SLTU)
// ----------------------------------------------------------------------------
module alu #(
  parameter int W    = alu_pkg::W,
  parameter int OP_W = alu_pkg::OP_W
) (
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  input  logic [OP_W-1:0] alu_op_i,
  output logic [W-1:0]    c_o,
  output logic            zero_o
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  logic [W-1:0]   add_res;

  assign shamt   = b_i[SHW-1:0];
  assign add_res = alu_pkg::alu_uses_sub(alu_op_i) ? (a_i - b_i) : (a_i + b_i);
  assign zero_o  = (add_res == '0);

  always_comb begin
    c_o = '0;
    case (alu_op_i)
      alu_pkg::ALU_ADD:  c_o = add_res;
      alu_pkg::ALU_SUB:  c_o = add_res;
      alu_pkg::ALU_AND:  c_o = a_i & b_i;
      alu_pkg::ALU_OR:   c_o = a_i | b_i;
      alu_pkg::ALU_XOR:  c_o = a_i ^ b_i;
      alu_pkg::ALU_SLL:  c_o = a_i << shamt;
      alu_pkg::ALU_SRL:  c_o = a_i >> shamt;
      alu_pkg::ALU_SRA:  c_o = $signed(a_i) >>> shamt;
      alu_pkg::ALU_SLT:  c_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      alu_pkg::ALU_SLTU: c_o = {{(W-1){1'b0}}, (a_i < b_i)};
      default:           c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// ----------------------------------------------------------------------------
// alu_rr_pick
// Two-input round-robin picker.
//   clk, rst_n   clock / asynchronous active-low reset
//   elig_i[1:0]  requester eligibility
//   upd_en_i     allow the last-grant pointer to move on a grant
//   grant_o[1:0] one-hot grant (all-zero when nobody is eligible)
// The pointer remembers the last winner; on conflict the other one wins.
// It resets to 1 so requester 0 takes the first conflict.
// ----------------------------------------------------------------------------
module alu_rr_pick
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig_i,
  input  logic       upd_en_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Next-state: pointer only moves on an actual grant
  always_comb begin
    last_d = last_q;
    if (upd_en_i && (grant_o != 2'b00)) begin
      last_d = grant_o[REQ_AUX];
    end
  end

  // Output: one-hot grant
  always_comb begin
    grant_o = 2'b00;
    case (elig_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Time-shares one combinational alu between requester 0 (EX datapath) and
// requester 1 (branch/aux compare). At most one grant per cycle, round-robin
// on conflict; each result is held in a per-requester response register
// until its owner accepts it.
//   clk, rst_n                    clock / asynchronous active-low reset
//   req_valid_x / req_ready_x     request handshake (ready = grant, comb.)
//   req_a_x, req_b_x, req_op_x    operands and opcode
//   resp_valid_x / resp_ready_x   response handshake
//   resp_c_x, resp_zero_x         held ALU result and zero flag
//   conflict_cnt                  saturating count of both-eligible cycles
// ----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::REQ_EX, alu_pkg::REQ_AUX;
#(
  parameter int W     = alu_pkg::W,
  parameter int OP_W  = alu_pkg::OP_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [W-1:0]     req_a_0,
  input  logic [W-1:0]     req_b_0,
  input  logic [OP_W-1:0]  req_op_0,
  output logic             resp_valid_0,
  input  logic             resp_ready_0,
  output logic [W-1:0]     resp_c_0,
  output logic             resp_zero_0,
  // requester 1
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [W-1:0]     req_a_1,
  input  logic [W-1:0]     req_b_1,
  input  logic [OP_W-1:0]  req_op_1,
  output logic             resp_valid_1,
  input  logic             resp_ready_1,
  output logic [W-1:0]     resp_c_1,
  output logic             resp_zero_1,
  // statistics
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [1:0]       req_valid;
  logic [1:0]       resp_ready;
  logic [1:0]       elig;
  logic [1:0]       grant;

  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [1:0]       resp_zero_q,  resp_zero_d;
  logic [W-1:0]     resp_c_q [2];
  logic [W-1:0]     resp_c_d [2];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     alu_a, alu_b, alu_c;
  logic [OP_W-1:0]  alu_op;
  logic             alu_zero;

  assign req_valid[REQ_EX]   = req_valid_0;
  assign req_valid[REQ_AUX]  = req_valid_1;
  assign resp_ready[REQ_EX]  = resp_ready_0;
  assign resp_ready[REQ_AUX] = resp_ready_1;

  // Per-requester eligibility and response register. A full register whose
  // owner is accepting this cycle counts as free, so it can drain and refill.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign elig[gi] = req_valid[gi] & (~resp_valid_q[gi] | resp_ready[gi]);

    always_comb begin
      resp_valid_d[gi] = resp_valid_q[gi];
      resp_c_d[gi]     = resp_c_q[gi];
      resp_zero_d[gi]  = resp_zero_q[gi];
      if (grant[gi]) begin
        resp_valid_d[gi] = 1'b1;
        resp_c_d[gi]     = alu_c;
        resp_zero_d[gi]  = alu_zero;
      end else if (resp_ready[gi]) begin
        resp_valid_d[gi] = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        resp_valid_q[gi] <= 1'b0;
        resp_c_q[gi]     <= '0;
        resp_zero_q[gi]  <= 1'b0;
      end else begin
        resp_valid_q[gi] <= resp_valid_d[gi];
        resp_c_q[gi]     <= resp_c_d[gi];
        resp_zero_q[gi]  <= resp_zero_d[gi];
      end
    end
  end

  // Every grant is a real handshake, so the pointer may always advance.
  alu_rr_pick u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .elig_i   (elig),
    .upd_en_i (1'b1),
    .grant_o  (grant)
  );

  assign req_ready_0 = grant[REQ_EX];
  assign req_ready_1 = grant[REQ_AUX];

  // With no grant the mux falls back to requester 0; that result is unused.
  assign alu_a  = grant[REQ_AUX] ? req_a_1  : req_a_0;
  assign alu_b  = grant[REQ_AUX] ? req_b_1  : req_b_0;
  assign alu_op = grant[REQ_AUX] ? req_op_1 : req_op_0;

  alu #(
    .W    (W),
    .OP_W (OP_W)
  ) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .alu_op_i (alu_op),
    .c_o      (alu_c),
    .zero_o   (alu_zero)
  );

  // Saturating conflict counter
  always_comb begin
    cnt_d = cnt_q;
    if ((elig == 2'b11) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign resp_valid_0 = resp_valid_q[REQ_EX];
  assign resp_c_0     = resp_c_q[REQ_EX];
  assign resp_zero_0  = resp_zero_q[REQ_EX];
  assign resp_valid_1 = resp_valid_q[REQ_AUX];
  assign resp_c_1     = resp_c_q[REQ_AUX];
  assign resp_zero_1  = resp_zero_q[REQ_AUX];
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_ready_0, resp_valid_0, resp_ready_0, resp_zero_0;
  logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1, resp_zero_1;
  logic [31:0] req_a_0, req_b_0, resp_c_0, req_a_1, req_b_1, resp_c_1;
  logic [3:0]  req_op_0, req_op_1;
  logic [15:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // op / a / b / expected c / expected zero
  logic [3:0]  t_op [10];
  logic [31:0] t_a  [10];
  logic [31:0] t_b  [10];
  logic [31:0] t_c  [10];
  logic        t_z  [10];

  always #5 clk = ~clk;

  alu_arbiter #(.W(32), .OP_W(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_op_0     (req_op_0),
    .resp_valid_0 (resp_valid_0),
    .resp_ready_0 (resp_ready_0),
    .resp_c_0     (resp_c_0),
    .resp_zero_0  (resp_zero_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .req_op_1     (req_op_1),
    .resp_valid_1 (resp_valid_1),
    .resp_ready_1 (resp_ready_1),
    .resp_c_1     (resp_c_1),
    .resp_zero_1  (resp_zero_1),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    t_op[0] = ALU_AND;  t_a[0] = 32'h0000F0F0; t_b[0] = 32'h0000FF00; t_c[0] = 32'h0000F000; t_z[0] = 1'b0;
    t_op[1] = ALU_OR;   t_a[1] = 32'h0000F0F0; t_b[1] = 32'h0000FF00; t_c[1] = 32'h0000FFF0; t_z[1] = 1'b0;
    t_op[2] = ALU_XOR;  t_a[2] = 32'h0000F0F0; t_b[2] = 32'h0000FF00; t_c[2] = 32'h00000FF0; t_z[2] = 1'b0;
    t_op[3] = ALU_SLL;  t_a[3] = 32'h00000001; t_b[3] = 32'h00000004; t_c[3] = 32'h00000010; t_z[3] = 1'b0;
    t_op[4] = ALU_SRA;  t_a[4] = 32'h80000000; t_b[4] = 32'h00000004; t_c[4] = 32'hF8000000; t_z[4] = 1'b0;
    t_op[5] = ALU_SRL;  t_a[5] = 32'h80000000; t_b[5] = 32'h00000004; t_c[5] = 32'h08000000; t_z[5] = 1'b0;
    t_op[6] = ALU_SLT;  t_a[6] = 32'hFFFFFFFF; t_b[6] = 32'h00000001; t_c[6] = 32'h00000001; t_z[6] = 1'b0;
    t_op[7] = ALU_SLTU; t_a[7] = 32'hFFFFFFFF; t_b[7] = 32'h00000001; t_c[7] = 32'h00000000; t_z[7] = 1'b0;
    t_op[8] = ALU_ADD;  t_a[8] = 32'hFFFFFFFF; t_b[8] = 32'h00000001; t_c[8] = 32'h00000000; t_z[8] = 1'b1;
    t_op[9] = ALU_SUB;  t_a[9] = 32'h00000003; t_b[9] = 32'h00000005; t_c[9] = 32'hFFFFFFFE; t_z[9] = 1'b0;
  end

  initial begin
    int g0;
    int g1;
    rst_n = 1'b0;
    req_valid_0 = 1'b0; req_a_0 = '0; req_b_0 = '0; req_op_0 = ALU_ADD; resp_ready_0 = 1'b0;
    req_valid_1 = 1'b0; req_a_1 = '0; req_b_1 = '0; req_op_1 = ALU_ADD; resp_ready_1 = 1'b0;

    // Reset state
    #2;
    chk("rst_valid0", {31'd0, resp_valid_0}, 32'd0);
    chk("rst_valid1", {31'd0, resp_valid_1}, 32'd0);
    chk("rst_c0", resp_c_0, 32'd0);
    chk("rst_zero0", {31'd0, resp_zero_0}, 32'd0);
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    chk("rst_ready0", {31'd0, req_ready_0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single requester 0: 5 + 3
    req_valid_0 = 1'b1; req_a_0 = 32'd5; req_b_0 = 32'd3; req_op_0 = ALU_ADD;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    settle();
    chk("t1_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("t1_ready1", {31'd0, req_ready_1}, 32'd0);
    tick();
    chk("t1_valid0", {31'd0, resp_valid_0}, 32'd1);
    chk("t1_c0", resp_c_0, 32'd8);
    chk("t1_zero0", {31'd0, resp_zero_0}, 32'd0);

    // Back-to-back opcode sweep on requester 0
    for (int i = 0; i < 10; i++) begin
      req_op_0 = t_op[i]; req_a_0 = t_a[i]; req_b_0 = t_b[i];
      settle();
      chk($sformatf("ops%0d_ready0", i), {31'd0, req_ready_0}, 32'd1);
      tick();
      chk($sformatf("ops%0d_c0", i), resp_c_0, t_c[i]);
      chk($sformatf("ops%0d_zero0", i), {31'd0, resp_zero_0}, {31'd0, t_z[i]});
    end
    req_valid_0 = 1'b0;
    settle();
    chk("drain_ready0", {31'd0, req_ready_0}, 32'd0);
    tick();
    chk("drain_valid0", {31'd0, resp_valid_0}, 32'd0);
    chk("single_cnt", {16'd0, conflict_cnt}, 32'd0);

    // First conflict after reset goes to requester 0
    do_reset();
    req_valid_0 = 1'b1; req_op_0 = ALU_SUB; req_a_0 = 32'd7; req_b_0 = 32'd7;
    req_valid_1 = 1'b1; req_op_1 = ALU_ADD; req_a_1 = 32'd1; req_b_1 = 32'd2;
    settle();
    chk("t2_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("t2_ready1", {31'd0, req_ready_1}, 32'd0);
    tick();
    chk("t2_valid0", {31'd0, resp_valid_0}, 32'd1);
    chk("t2_c0", resp_c_0, 32'd0);
    chk("t2_zero0", {31'd0, resp_zero_0}, 32'd1);
    chk("t2_cnt_a", {16'd0, conflict_cnt}, 32'd1);
    req_valid_0 = 1'b0;
    settle();
    chk("t2_ready1b", {31'd0, req_ready_1}, 32'd1);
    tick();
    chk("t2_valid1", {31'd0, resp_valid_1}, 32'd1);
    chk("t2_c1", resp_c_1, 32'd3);
    chk("t2_zero1", {31'd0, resp_zero_1}, 32'd0);
    chk("t2_valid0_clr", {31'd0, resp_valid_0}, 32'd0);
    chk("t2_cnt_b", {16'd0, conflict_cnt}, 32'd1);
    req_valid_1 = 1'b0;
    tick();

    // Sustained contention: grants alternate 0,1,0,1...
    g0 = 0; g1 = 0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_op_0 = ALU_ADD; req_op_1 = ALU_SUB;
    for (int i = 0; i < 10; i++) begin
      req_a_0 = i; req_b_0 = 32'd10;
      req_a_1 = 32'd100; req_b_1 = i;
      settle();
      chk($sformatf("rr%0d_ready0", i), {31'd0, req_ready_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_ready1", i), {31'd0, req_ready_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      g0 += int'(req_ready_0);
      g1 += int'(req_ready_1);
      tick();
      if (i % 2 == 0) chk($sformatf("rr%0d_c0", i), resp_c_0, i + 10);
      else            chk($sformatf("rr%0d_c1", i), resp_c_1, 100 - i);
    end
    chk("rr_grants0", g0, 32'd5);
    chk("rr_grants1", g1, 32'd5);
    chk("rr_cnt", {16'd0, conflict_cnt}, 32'd11);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tick();

    // Backpressure on requester 1
    resp_ready_1 = 1'b0;
    req_valid_1 = 1'b1; req_op_1 = ALU_ADD; req_a_1 = 32'd1; req_b_1 = 32'd1;
    settle();
    chk("bp_setup_ready1", {31'd0, req_ready_1}, 32'd1);
    tick();
    chk("bp_setup_valid1", {31'd0, resp_valid_1}, 32'd1);
    chk("bp_setup_c1", resp_c_1, 32'd2);
    req_a_1 = 32'd20; req_b_1 = 32'd22;
    req_valid_0 = 1'b1; req_op_0 = ALU_ADD;
    for (int i = 0; i < 4; i++) begin
      req_a_0 = i; req_b_0 = 32'd100;
      settle();
      chk($sformatf("bp%0d_ready0", i), {31'd0, req_ready_0}, 32'd1);
      chk($sformatf("bp%0d_ready1", i), {31'd0, req_ready_1}, 32'd0);
      tick();
      chk($sformatf("bp%0d_c0", i), resp_c_0, i + 100);
      chk($sformatf("bp%0d_c1_held", i), resp_c_1, 32'd2);
    end
    chk("bp_cnt", {16'd0, conflict_cnt}, 32'd11);
    resp_ready_1 = 1'b1;
    settle();
    chk("bp_refill_ready1", {31'd0, req_ready_1}, 32'd1);
    chk("bp_refill_ready0", {31'd0, req_ready_0}, 32'd0);
    tick();
    chk("bp_refill_valid1", {31'd0, resp_valid_1}, 32'd1);
    chk("bp_refill_c1", resp_c_1, 32'd42);
    chk("bp_refill_cnt", {16'd0, conflict_cnt}, 32'd12);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tick();

    // Saturation: 2^16+3 contested cycles
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    repeat (65539) @(posedge clk);
    #1;
    chk("sat_cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
    tick();
    chk("sat_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);

    // Asynchronous reset mid-stream
    req_valid_1 = 1'b0;
    req_op_0 = ALU_ADD; req_a_0 = 32'd1; req_b_0 = 32'd1;
    tick();
    chk("ar_pre_valid0", {31'd0, resp_valid_0}, 32'd1);
    chk("ar_pre_c0", resp_c_0, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid0", {31'd0, resp_valid_0}, 32'd0);
    chk("ar_c0", resp_c_0, 32'd0);
    chk("ar_cnt", {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_1 = 1'b1;
    settle();
    chk("ar_first_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("ar_first_ready1", {31'd0, req_ready_1}, 32'd0);
    tick();
    chk("ar_first_cnt", {16'd0, conflict_cnt}, 32'd1);
    chk("ar_first_c0", resp_c_0, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
